// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard bus between the datapath and hazard_stall_ctrl.
// The datapath (master) presents the D/E/M instruction registers.
// The controller (slave) returns the stall and MDU sequencing signals.
interface hazard_stall_ctrl_if;
  logic [31:0] ir_d;
  logic [31:0] ir_e;
  logic [31:0] ir_m;
  logic        stall;
  logic        md_start;
  logic [1:0]  md_op;
  logic        md_busy;
  logic [3:0]  md_cnt;

  modport master (
    output ir_d, ir_e, ir_m,
    input  stall, md_start, md_op, md_busy, md_cnt
  );

  modport slave (
    input  ir_d, ir_e, ir_m,
    output stall, md_start, md_op, md_busy, md_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall and multiply/divide sequencing controller for the 5-stage MIPS pipeline.
// Latency: stall/md_start/md_op combinational; md_cnt registered (md_busy follows it).
// Backpressure: stall freezes PC and F/D and bubbles D/E until every hazard clears.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave bus
);

  // Opcode and funct encodings of the decoded instruction subset
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  // Source-operand requirements of the D-stage instruction
  typedef struct packed {
    logic       rs_used;
    logic [1:0] rs_tuse;
    logic       rt_used;
    logic [1:0] rt_tuse;
  } src_t;

  // Destination produced by an in-flight instruction and when it becomes ready
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } dst_t;

  // MDU issue information for the E-stage instruction
  typedef struct packed {
    logic       start;
    logic [1:0] op;
  } md_iss_t;

  function automatic logic is_rfn(input logic [31:0] ir, input logic [5:0] fn);
    return (ir[31:26] == OP_RTYPE) && (ir[5:0] == fn);
  endfunction

  // Which sources the instruction reads in D and how soon it needs them
  function automatic src_t decode_src(input logic [31:0] ir);
    src_t s;
    s = '0;
    if (is_rfn(ir, FN_ADDU) || is_rfn(ir, FN_SUBU) ||
        is_rfn(ir, FN_MULT) || is_rfn(ir, FN_MULTU) ||
        is_rfn(ir, FN_DIV)  || is_rfn(ir, FN_DIVU)) begin
      s.rs_used = 1'b1;
      s.rs_tuse = 2'd1;
      s.rt_used = 1'b1;
      s.rt_tuse = 2'd1;
    end else if (is_rfn(ir, FN_JR)) begin
      s.rs_used = 1'b1;
      s.rs_tuse = 2'd0;
    end else if (is_rfn(ir, FN_MTHI) || is_rfn(ir, FN_MTLO)) begin
      s.rs_used = 1'b1;
      s.rs_tuse = 2'd1;
    end else begin
      case (ir[31:26])
        OP_ORI, OP_LW: begin
          s.rs_used = 1'b1;
          s.rs_tuse = 2'd1;
        end
        OP_SW: begin
          s.rs_used = 1'b1;
          s.rs_tuse = 2'd1;
          s.rt_used = 1'b1;
          s.rt_tuse = 2'd2;
        end
        OP_BEQ: begin
          s.rs_used = 1'b1;
          s.rs_tuse = 2'd0;
          s.rt_used = 1'b1;
          s.rt_tuse = 2'd0;
        end
        default: s = '0;
      endcase
    end
    return s;
  endfunction

  // Destination register and Tnew; in_m selects the M-stage view (only lw still pending)
  function automatic dst_t decode_dst(input logic [31:0] ir, input logic in_m);
    dst_t d;
    d = '0;
    if (is_rfn(ir, FN_ADDU) || is_rfn(ir, FN_SUBU) ||
        is_rfn(ir, FN_MFHI) || is_rfn(ir, FN_MFLO)) begin
      d.dst  = ir[15:11];
      d.tnew = in_m ? 2'd0 : 2'd1;
    end else begin
      case (ir[31:26])
        OP_ORI, OP_LUI: begin
          d.dst  = ir[20:16];
          d.tnew = in_m ? 2'd0 : 2'd1;
        end
        OP_LW: begin
          d.dst  = ir[20:16];
          d.tnew = in_m ? 2'd1 : 2'd2;
        end
        OP_JAL: begin
          d.dst  = 5'd31;
          d.tnew = 2'd0;
        end
        default: d = '0;
      endcase
    end
    return d;
  endfunction

  // Any instruction touching HI/LO must wait for the MDU to be idle
  function automatic logic is_md_class(input logic [31:0] ir);
    return is_rfn(ir, FN_MULT) || is_rfn(ir, FN_MULTU) ||
           is_rfn(ir, FN_DIV)  || is_rfn(ir, FN_DIVU)  ||
           is_rfn(ir, FN_MFHI) || is_rfn(ir, FN_MFLO)  ||
           is_rfn(ir, FN_MTHI) || is_rfn(ir, FN_MTLO);
  endfunction

  // Start pulse and opcode for mult/multu/div/divu; op stays 00 otherwise
  function automatic md_iss_t decode_md(input logic [31:0] ir);
    md_iss_t m;
    m = '0;
    if (is_rfn(ir, FN_MULT)) begin
      m.start = 1'b1;
      m.op    = 2'b00;
    end else if (is_rfn(ir, FN_MULTU)) begin
      m.start = 1'b1;
      m.op    = 2'b01;
    end else if (is_rfn(ir, FN_DIV)) begin
      m.start = 1'b1;
      m.op    = 2'b10;
    end else if (is_rfn(ir, FN_DIVU)) begin
      m.start = 1'b1;
      m.op    = 2'b11;
    end
    return m;
  endfunction

  // A source stalls on a producer if it is a real register that will not be ready in time
  function automatic logic src_hazard(input logic used, input logic [4:0] s,
                                      input logic [1:0] tuse, input dst_t p);
    return used && (s != 5'd0) && (s == p.dst) && (p.tnew > tuse);
  endfunction

  src_t       src_d;
  dst_t       dst_e;
  dst_t       dst_m;
  md_iss_t    md_e;
  logic       md_class_d;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic       data_hz;
  logic       md_hz;
  logic       md_busy;
  logic [3:0] md_cnt_q;
  logic [3:0] md_cnt_d;

  assign src_d      = decode_src(bus.ir_d);
  assign dst_e      = decode_dst(bus.ir_e, 1'b0);
  assign dst_m      = decode_dst(bus.ir_m, 1'b1);
  assign md_e       = decode_md(bus.ir_e);
  assign md_class_d = is_md_class(bus.ir_d);
  assign rs_d       = bus.ir_d[25:21];
  assign rt_d       = bus.ir_d[20:16];

  // Data hazards: each D source against the E and M producers
  always_comb begin
    data_hz = 1'b0;
    data_hz = src_hazard(src_d.rs_used, rs_d, src_d.rs_tuse, dst_e) ||
              src_hazard(src_d.rs_used, rs_d, src_d.rs_tuse, dst_m) ||
              src_hazard(src_d.rt_used, rt_d, src_d.rt_tuse, dst_e) ||
              src_hazard(src_d.rt_used, rt_d, src_d.rt_tuse, dst_m);
  end

  // MDU is busy from the cycle it starts until the countdown drains
  assign md_busy = md_e.start || (md_cnt_q != 4'd0);
  assign md_hz   = md_class_d && md_busy;

  // Countdown next state: load on start (reload if already counting), else drain
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_e.start) begin
      md_cnt_d = md_e.op[1] ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  // Countdown register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= 4'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign bus.stall    = data_hz || md_hz;
  assign bus.md_start = md_e.start;
  assign bus.md_op    = md_e.op;
  assign bus.md_busy  = md_busy;
  assign bus.md_cnt   = md_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed pipeline scenarios then randomized instruction mixes.
// Expected outputs come from a mnemonic-level model of Tuse/Tnew and the MDU busy window.
module tb_hazard_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef enum logic [4:0] {
    M_ADDU, M_SUBU, M_JR, M_MULT, M_MULTU, M_DIV, M_DIVU, M_MFHI, M_MFLO,
    M_MTHI, M_MTLO, M_ORI, M_LW, M_SW, M_BEQ, M_LUI, M_J, M_JAL,
    M_NOP, M_ADDI, M_ADD
  } mn_e;

  typedef struct {
    mn_e mn;
    int  rs;
    int  rt;
    int  rd;
  } instr_t;

  logic clk;
  logic reset;
  hazard_stall_ctrl_if bus();

  hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_cmp  = 0;
  int     n_fail = 0;
  int     cnt_m  = 0;
  instr_t cur_d, cur_e, cur_m;

  function automatic instr_t mk(input mn_e mn, input int rs, input int rt, input int rd);
    instr_t i;
    i.mn = mn; i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic logic [31:0] enc(input instr_t i);
    logic [4:0] s, t, d;
    s = 5'(i.rs); t = 5'(i.rt); d = 5'(i.rd);
    case (i.mn)
      M_ADDU:  return {6'h00, s, t, d, 5'd0, 6'h21};
      M_SUBU:  return {6'h00, s, t, d, 5'd0, 6'h23};
      M_ADD:   return {6'h00, s, t, d, 5'd0, 6'h20};
      M_JR:    return {6'h00, s, 15'd0, 6'h08};
      M_MULT:  return {6'h00, s, t, 10'd0, 6'h18};
      M_MULTU: return {6'h00, s, t, 10'd0, 6'h19};
      M_DIV:   return {6'h00, s, t, 10'd0, 6'h1A};
      M_DIVU:  return {6'h00, s, t, 10'd0, 6'h1B};
      M_MFHI:  return {6'h00, 10'd0, d, 5'd0, 6'h10};
      M_MFLO:  return {6'h00, 10'd0, d, 5'd0, 6'h12};
      M_MTHI:  return {6'h00, s, 15'd0, 6'h11};
      M_MTLO:  return {6'h00, s, 15'd0, 6'h13};
      M_ORI:   return {6'h0D, s, t, 16'h00F0};
      M_LW:    return {6'h23, s, t, 16'h0004};
      M_SW:    return {6'h2B, s, t, 16'h0008};
      M_BEQ:   return {6'h04, s, t, 16'hFFFE};
      M_LUI:   return {6'h0F, s, t, 16'h1234};
      M_J:     return {6'h02, s, t, 16'h0040};
      M_JAL:   return {6'h03, s, t, 16'h0080};
      M_ADDI:  return {6'h08, s, t, 16'h0011};
      default: return 32'h0;
    endcase
  endfunction

  // Cycles until the D stage needs each operand; -1 when the operand is not read
  function automatic int tuse_rs(input mn_e mn);
    case (mn)
      M_BEQ, M_JR: return 0;
      M_ADDU, M_SUBU, M_ORI, M_LW, M_SW, M_MULT, M_MULTU, M_DIV, M_DIVU,
      M_MTHI, M_MTLO: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic int tuse_rt(input mn_e mn);
    case (mn)
      M_BEQ: return 0;
      M_ADDU, M_SUBU, M_MULT, M_MULTU, M_DIV, M_DIVU: return 1;
      M_SW: return 2;
      default: return -1;
    endcase
  endfunction

  function automatic int dest(input instr_t i);
    case (i.mn)
      M_ADDU, M_SUBU, M_MFHI, M_MFLO: return i.rd;
      M_ORI, M_LUI, M_LW: return i.rt;
      M_JAL: return 31;
      default: return 0;
    endcase
  endfunction

  function automatic int tnew_e(input mn_e mn);
    if (mn == M_LW) return 2;
    if (mn == M_JAL) return 0;
    return 1;
  endfunction

  function automatic int tnew_m(input mn_e mn);
    return (mn == M_LW) ? 1 : 0;
  endfunction

  function automatic bit is_mdu(input mn_e mn);
    return mn inside {M_MULT, M_MULTU, M_DIV, M_DIVU};
  endfunction

  function automatic bit is_hilo(input mn_e mn);
    return is_mdu(mn) || (mn inside {M_MFHI, M_MFLO, M_MTHI, M_MTLO});
  endfunction

  function automatic int md_code(input mn_e mn);
    case (mn)
      M_MULTU: return 1;
      M_DIV:   return 2;
      M_DIVU:  return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit src_hz(input int tuse, input int s, input instr_t e, input instr_t m);
    if (tuse < 0 || s == 0) return 0;
    if (s == dest(e) && tnew_e(e.mn) > tuse) return 1;
    if (s == dest(m) && tnew_m(m.mn) > tuse) return 1;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input instr_t d, input instr_t e, input instr_t m, input logic rst);
    cur_d = d; cur_e = e; cur_m = m;
    bus.ir_d = enc(d);
    bus.ir_e = enc(e);
    bus.ir_m = enc(m);
    reset    = rst;
  endtask

  // Compare all outputs against the model at the falling edge
  task automatic sample(input string tag);
    bit start, busy, stl;
    @(negedge clk);
    start = is_mdu(cur_e.mn);
    busy  = start || (cnt_m != 0);
    stl   = src_hz(tuse_rs(cur_d.mn), cur_d.rs, cur_e, cur_m) ||
            src_hz(tuse_rt(cur_d.mn), cur_d.rt, cur_e, cur_m) ||
            (is_hilo(cur_d.mn) && busy);
    check({tag, ".stall"},    32'(bus.stall),    32'(stl));
    check({tag, ".md_start"}, 32'(bus.md_start), 32'(start));
    check({tag, ".md_op"},    32'(bus.md_op),    start ? md_code(cur_e.mn) : 0);
    check({tag, ".md_busy"},  32'(bus.md_busy),  32'(busy));
    check({tag, ".md_cnt"},   32'(bus.md_cnt),   cnt_m);
  endtask

  // Clock edge: advance the model's busy window the same way the unit counts
  task automatic advance();
    @(posedge clk);
    if (reset)                  cnt_m = 0;
    else if (is_mdu(cur_e.mn))  cnt_m = (cur_e.mn inside {M_MULT, M_MULTU}) ? MULT_N : DIV_N;
    else if (cnt_m != 0)        cnt_m = cnt_m - 1;
    #1;
  endtask

  instr_t nop;

  initial begin
    nop = mk(M_NOP, 0, 0, 0);
    drive(nop, nop, nop, 1'b1);
    advance();
    drive(nop, nop, nop, 1'b0);
    sample("reset");
    check("reset.cnt_lit", 32'(bus.md_cnt), 0);
    check("reset.stall_lit", 32'(bus.stall), 0);
    advance();

    // lw $1 in E, addu $2,$1,$3 in D: one stall cycle
    drive(mk(M_ADDU, 1, 3, 2), mk(M_LW, 0, 1, 0), nop, 1'b0);
    sample("lw_addu0"); check("lw_addu0.lit", 32'(bus.stall), 1); advance();
    drive(mk(M_ADDU, 1, 3, 2), nop, mk(M_LW, 0, 1, 0), 1'b0);
    sample("lw_addu1"); check("lw_addu1.lit", 32'(bus.stall), 0); advance();

    // addu $1 in E, beq $1,$2 in D: one stall cycle
    drive(mk(M_BEQ, 1, 2, 0), mk(M_ADDU, 4, 5, 1), nop, 1'b0);
    sample("addu_beq0"); check("addu_beq0.lit", 32'(bus.stall), 1); advance();
    drive(mk(M_BEQ, 1, 2, 0), nop, mk(M_ADDU, 4, 5, 1), 1'b0);
    sample("addu_beq1"); check("addu_beq1.lit", 32'(bus.stall), 0); advance();

    // lw $1 in E, beq $1 in D: two stall cycles
    drive(mk(M_BEQ, 1, 2, 0), mk(M_LW, 0, 1, 0), nop, 1'b0);
    sample("lw_beq0"); check("lw_beq0.lit", 32'(bus.stall), 1); advance();
    drive(mk(M_BEQ, 1, 2, 0), nop, mk(M_LW, 0, 1, 0), 1'b0);
    sample("lw_beq1"); check("lw_beq1.lit", 32'(bus.stall), 1); advance();
    drive(mk(M_BEQ, 1, 2, 0), nop, nop, 1'b0);
    sample("lw_beq2"); check("lw_beq2.lit", 32'(bus.stall), 0); advance();

    // mult in E with mflo waiting in D
    drive(mk(M_MFLO, 0, 0, 7), mk(M_MULT, 2, 3, 0), nop, 1'b0);
    sample("mult0");
    check("mult0.start_lit", 32'(bus.md_start), 1);
    check("mult0.op_lit", 32'(bus.md_op), 0);
    advance();
    for (int k = 1; k <= 6; k++) begin
      drive(mk(M_MFLO, 0, 0, 7), nop, (k == 1) ? mk(M_MULT, 2, 3, 0) : nop, 1'b0);
      sample("mult_cd");
      check("mult_cd.cnt_lit", 32'(bus.md_cnt), 6 - k);
      check("mult_cd.stall_lit", 32'(bus.stall), (k <= 5) ? 1 : 0);
      check("mult_cd.start_lit", 32'(bus.md_start), 0);
      advance();
    end
    drive(nop, mk(M_MFLO, 0, 0, 7), nop, 1'b0);
    sample("mflo_e"); advance();

    // divu then reset mid-countdown
    drive(nop, mk(M_DIVU, 2, 3, 0), nop, 1'b0);
    sample("divu0"); check("divu0.op_lit", 32'(bus.md_op), 3); advance();
    drive(nop, nop, mk(M_DIVU, 2, 3, 0), 1'b0);
    sample("divu1"); check("divu1.cnt_lit", 32'(bus.md_cnt), 10); advance();
    drive(nop, nop, nop, 1'b0);
    sample("divu2"); advance();
    drive(mk(M_MTHI, 4, 0, 0), nop, nop, 1'b1);
    sample("divu3"); check("divu3.cnt_lit", 32'(bus.md_cnt), 8);
    check("divu3.mthi_stall_lit", 32'(bus.stall), 1); advance();
    drive(nop, nop, nop, 1'b0);
    sample("divu4");
    check("divu4.cnt_lit", 32'(bus.md_cnt), 0);
    check("divu4.busy_lit", 32'(bus.md_busy), 0);
    advance();

    // Boundary cases that must not stall, plus sw base register that must
    drive(mk(M_ADDU, 0, 0, 2), mk(M_LW, 0, 0, 0), nop, 1'b0);
    sample("lw_r0"); check("lw_r0.lit", 32'(bus.stall), 0); advance();
    drive(mk(M_SW, 5, 1, 0), mk(M_LW, 0, 1, 0), nop, 1'b0);
    sample("lw_sw_rt"); check("lw_sw_rt.lit", 32'(bus.stall), 0); advance();
    drive(mk(M_SW, 1, 5, 0), mk(M_LW, 0, 1, 0), nop, 1'b0);
    sample("lw_sw_rs"); check("lw_sw_rs.lit", 32'(bus.stall), 1); advance();
    drive(mk(M_JR, 31, 0, 0), mk(M_JAL, 0, 0, 0), nop, 1'b0);
    sample("jal_jr"); check("jal_jr.lit", 32'(bus.stall), 0); advance();
    drive(mk(M_ADDU, 9, 9, 3), mk(M_ADD, 4, 5, 9), mk(M_ADDI, 1, 9, 0), 1'b0);
    sample("undecoded"); check("undecoded.lit", 32'(bus.stall), 0); advance();

    // Randomized instruction mixes with small register numbers to force collisions
    for (int n = 0; n < 600; n++) begin
      instr_t r[3];
      for (int j = 0; j < 3; j++) begin
        r[j] = mk(mn_e'($urandom_range(0, 20)), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) r[j].rs = 31;
      end
      drive(r[0], r[1], r[2], ($urandom_range(0, 49) == 0));
      sample("rnd");
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
